fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 stall_decode  in  1  from hazard unit; holds PC and the IF/ID register.
REQ-005 flush_decode  in  1  clears the IF/ID register to a bubble.
REQ-006 pc_source_decode  in  2  bit0 = branch taken, bit1 = jump.
REQ-007 jump_pc_decode  in  1  register-target jump (jr).
REQ-008 pc_branch_decode, pc_jump_decode, pc_register_decode  in  32 each  redirect targets.
REQ-009 imem_req  out  1; imem_addr  out  32; imem_ack  in  1; imem_rdata  in  32  instruction-memory handshake.
REQ-010 instr_decode  out  32; pc_plus4_decode  out  32; valid_decode  out  1  IF/ID register contents.
REQ-011 opcode_decode  out  6 = instr_decode[31:26]; funct_decode  out  6 = instr_decode[5:0].

Function
REQ-012 Redirect, decode-cycle view: target priority is jump_pc_decode (pc_register_decode), then pc_source_decode[1] (pc_jump_decode), then pc_source_decode[0] (pc_branch_decode); otherwise PC+4.
REQ-013 Redirect inputs are honoured only when stall_decode=0.
REQ-014 The FSM has three states:
- BOOT: imem_req=0; goes to REQ after one cycle.
- REQ: imem_req=1, imem_addr=PC.
- HELD: imem_req=0, rdata buffered.
REQ-015 While in REQ with imem_req=1 and imem_ack=0, imem_addr holds stable.
REQ-016 REQ, imem_ack=1, stall_decode=0, no redirect: IF/ID <= {imem_rdata, PC+4, valid=1}; PC <= PC+4; FSM stays in REQ.
REQ-017 REQ, imem_ack=1, stall_decode=1: imem_rdata goes into the hold buffer; PC and IF/ID are unchanged; FSM goes to HELD.
REQ-018 HELD with stall_decode=0: IF/ID <= buffer (valid=1); PC <= PC+4; FSM goes to REQ.
REQ-019 HELD with stall_decode=1: nothing changes.
REQ-020 REQ, imem_ack=0, stall_decode=0: IF/ID <= {32'h0, PC+4, valid=0} (bubble).
REQ-021 Redirect accepted in the same cycle as imem_ack: the fetched word is discarded; IF/ID <= bubble; PC <= target.
REQ-022 Redirect accepted while imem_ack=0: the target is latched as a pending redirect; imem_addr stays on the old PC.
- On the next ack, the data is discarded, IF/ID <= bubble, PC <= pending target, and the pending flag is cleared.
REQ-023 A new redirect while one is pending overwrites the pending target; the newest redirect wins.
REQ-024 flush_decode=1 forces IF/ID to a bubble regardless of stall_decode, and overrides any load in that cycle.
- PC/FSM behaviour is unaffected by flush_decode.
REQ-025 PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0.
REQ-026 pc_plus4_decode is 32'h0 while in BOOT; opcode_decode and funct_decode are purely combinational.

Reset
REQ-027 While reset=0, all of the following hold:
- PC = RESET_PC, FSM = BOOT.
- imem_req=0.
- instr_decode=0, pc_plus4_decode=0, valid_decode=0.
- Pending redirect and hold buffer are cleared.
REQ-028 Reset asserted mid-request drops imem_req asynchronously; the abandoned transaction is never consumed.
REQ-029 After reset is released, the first imem_req rises on the second rising edge, with imem_addr=RESET_PC.

Verification
REQ-030 Streaming, zero-wait ack, words A,B,C from 0x0, 0x4, 0x8 -> instr_decode = A, B, C on consecutive cycles; pc_plus4_decode = 0x4, 0x8, 0xC.
REQ-031 Ack delayed 3 cycles at PC=0x10 -> imem_addr holds 0x10; three bubbles (valid=0); then the word appears with pc_plus4_decode=0x14.
REQ-032 stall_decode=1 for 2 cycles coincident with ack of 0x20 -> FSM enters HELD and imem_req=0; on release the word is loaded and the next imem_addr=0x24.
REQ-033 Branch taken to 0x100 while the ack for 0x40 is pending -> 0x40 data is discarded; the next imem_addr=0x100.
- Same cycle, jump_pc_decode=1 with pc_register_decode=0x200 -> 0x200 wins.
REQ-034 flush_decode=1 together with ack -> valid_decode=0 and instr_decode=0; PC still advances.
REQ-035 reset pulled low mid-wait at PC=0x80 -> imem_req drops immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage of a classic five-stage pipeline. Owns the PC,
// drives a simple req/ack instruction-memory handshake and produces the
// IF/ID pipeline register consumed by decode.
//
// Ports
//   clk                 single clock, rising edge
//   reset               asynchronous, active-low
//   stall_decode        hazard stall: holds PC and IF/ID
//   flush_decode        forces IF/ID to a bubble
//   pc_source_decode    bit0 = branch taken, bit1 = jump
//   jump_pc_decode      register-target jump (jr)
//   pc_branch_decode    branch target
//   pc_jump_decode      jump target
//   pc_register_decode  register jump target
//   imem_req/imem_addr  fetch request and address (address = PC)
//   imem_ack/imem_rdata memory acknowledge and returned word
//   instr_decode        IF/ID instruction
//   pc_plus4_decode     IF/ID PC+4
//   valid_decode        IF/ID valid (0 = bubble)
//   opcode_decode       instr_decode[31:26]
//   funct_decode        instr_decode[5:0]
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_decode,
    input  logic        flush_decode,
    input  logic [1:0]  pc_source_decode,
    input  logic        jump_pc_decode,
    input  logic [31:0] pc_branch_decode,
    input  logic [31:0] pc_jump_decode,
    input  logic [31:0] pc_register_decode,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_decode,
    output logic [31:0] pc_plus4_decode,
    output logic        valid_decode,
    output logic [5:0]  opcode_decode,
    output logic [5:0]  funct_decode
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HELD = 2'd2
    } state_t;

    state_t      state;
    logic        boot_done;
    logic [31:0] pc;
    logic        pending;
    logic [31:0] pending_pc;
    logic [31:0] hold_buf;

    logic        redirect;
    logic        take_redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Redirect target priority: jr, then jump, then taken branch.
    always_comb begin
        target = pc_branch_decode;
        if (jump_pc_decode)
            target = pc_register_decode;
        else if (pc_source_decode[1])
            target = pc_jump_decode;
    end

    assign redirect      = jump_pc_decode | pc_source_decode[1] | pc_source_decode[0];
    assign take_redirect = redirect & ~stall_decode;
    assign pc_plus4      = pc + 32'd4;  // wraps modulo 2^32

    assign imem_addr     = pc;
    assign opcode_decode = instr_decode[31:26];
    assign funct_decode  = instr_decode[5:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= BOOT;
            boot_done       <= 1'b0;
            imem_req        <= 1'b0;
            pc              <= RESET_PC;
            pending         <= 1'b0;
            pending_pc      <= 32'h0;
            hold_buf        <= 32'h0;
            instr_decode    <= 32'h0;
            pc_plus4_decode <= 32'h0;
            valid_decode    <= 1'b0;
        end else begin
            case (state)
                // One idle cycle after reset before the first request.
                BOOT: begin
                    if (boot_done) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end else begin
                        boot_done <= 1'b1;
                    end
                end

                REQ: begin
                    if (imem_ack) begin
                        if (take_redirect) begin
                            // Word fetched from the wrong path: drop it.
                            pc              <= target;
                            pending         <= 1'b0;
                            instr_decode    <= 32'h0;
                            pc_plus4_decode <= pc_plus4;
                            valid_decode    <= 1'b0;
                        end else if (pending) begin
                            // Completes the transaction that was in flight when
                            // the redirect arrived; its data is stale.
                            pc      <= pending_pc;
                            pending <= 1'b0;
                            if (!stall_decode) begin
                                instr_decode    <= 32'h0;
                                pc_plus4_decode <= pc_plus4;
                                valid_decode    <= 1'b0;
                            end
                        end else if (stall_decode) begin
                            hold_buf <= imem_rdata;
                            state    <= HELD;
                            imem_req <= 1'b0;
                        end else begin
                            pc              <= pc_plus4;
                            instr_decode    <= imem_rdata;
                            pc_plus4_decode <= pc_plus4;
                            valid_decode    <= 1'b1;
                        end
                    end else if (!stall_decode) begin
                        // Address must stay put until ack, so a redirect is
                        // parked; the newest one overwrites an older one.
                        instr_decode    <= 32'h0;
                        pc_plus4_decode <= pc_plus4;
                        valid_decode    <= 1'b0;
                        if (take_redirect) begin
                            pending    <= 1'b1;
                            pending_pc <= target;
                        end
                    end
                end

                HELD: begin
                    if (!stall_decode) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                        if (take_redirect) begin
                            pc              <= target;
                            instr_decode    <= 32'h0;
                            pc_plus4_decode <= pc_plus4;
                            valid_decode    <= 1'b0;
                        end else begin
                            pc              <= pc_plus4;
                            instr_decode    <= hold_buf;
                            pc_plus4_decode <= pc_plus4;
                            valid_decode    <= 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                end
            endcase

            // Flush wins over any load or hold of IF/ID this cycle.
            if (flush_decode) begin
                instr_decode <= 32'h0;
                valid_decode <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed bench for fetch_stage: streaming fetch, wait states, stall/hold,
// pending and same-cycle redirects, flush, PC wrap and mid-request reset.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall_decode;
    logic        flush_decode;
    logic [1:0]  pc_source_decode;
    logic        jump_pc_decode;
    logic [31:0] pc_branch_decode;
    logic [31:0] pc_jump_decode;
    logic [31:0] pc_register_decode;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_decode;
    logic [31:0] pc_plus4_decode;
    logic        valid_decode;
    logic [5:0]  opcode_decode;
    logic [5:0]  funct_decode;

    int tests = 0;
    int fails = 0;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .reset             (reset),
        .stall_decode      (stall_decode),
        .flush_decode      (flush_decode),
        .pc_source_decode  (pc_source_decode),
        .jump_pc_decode    (jump_pc_decode),
        .pc_branch_decode  (pc_branch_decode),
        .pc_jump_decode    (pc_jump_decode),
        .pc_register_decode(pc_register_decode),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .instr_decode      (instr_decode),
        .pc_plus4_decode   (pc_plus4_decode),
        .valid_decode      (valid_decode),
        .opcode_decode     (opcode_decode),
        .funct_decode      (funct_decode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirect();
        pc_source_decode   = 2'b00;
        jump_pc_decode     = 1'b0;
    endtask

    initial begin
        reset              = 1'b0;
        stall_decode       = 1'b0;
        flush_decode       = 1'b0;
        pc_source_decode   = 2'b00;
        jump_pc_decode     = 1'b0;
        pc_branch_decode   = 32'h0;
        pc_jump_decode     = 32'h0;
        pc_register_decode = 32'h0;
        imem_ack           = 1'b0;
        imem_rdata         = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_req",   {31'h0, imem_req}, 32'h0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_instr", instr_decode, 32'h0);
        chk("rst_pc4",   pc_plus4_decode, 32'h0);
        chk("rst_valid", {31'h0, valid_decode}, 32'h0);

        // Release; first request on the second rising edge
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("boot_req",  {31'h0, imem_req}, 32'h0);
        chk("boot_pc4",  pc_plus4_decode, 32'h0);
        tick();
        chk("first_req",  {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);

        // Zero-wait streaming A, B, C
        imem_ack   = 1'b1;
        imem_rdata = 32'h8C22_0010;
        tick();
        chk("strA_instr", instr_decode, 32'h8C22_0010);
        chk("strA_pc4",   pc_plus4_decode, 32'h4);
        chk("strA_valid", {31'h0, valid_decode}, 32'h1);
        chk("strA_opc",   {26'h0, opcode_decode}, 32'h23);
        chk("strA_fun",   {26'h0, funct_decode}, 32'h10);
        chk("strA_addr",  imem_addr, 32'h4);
        imem_rdata = 32'h2401_0005;
        tick();
        chk("strB_instr", instr_decode, 32'h2401_0005);
        chk("strB_pc4",   pc_plus4_decode, 32'h8);
        imem_rdata = 32'h0221_802A;
        tick();
        chk("strC_instr", instr_decode, 32'h0221_802A);
        chk("strC_pc4",   pc_plus4_decode, 32'hC);
        chk("strC_fun",   {26'h0, funct_decode}, 32'h2A);
        imem_rdata = 32'h1111_0000;
        tick();
        chk("strD_addr",  imem_addr, 32'h10);

        // Ack delayed three cycles at 0x10
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_addr",  imem_addr, 32'h10);
            chk("wait_valid", {31'h0, valid_decode}, 32'h0);
            chk("wait_req",   {31'h0, imem_req}, 32'h1);
        end
        chk("wait_pc4", pc_plus4_decode, 32'h14);
        imem_ack   = 1'b1;
        imem_rdata = 32'h2222_0001;
        tick();
        chk("late_instr", instr_decode, 32'h2222_0001);
        chk("late_pc4",   pc_plus4_decode, 32'h14);
        chk("late_valid", {31'h0, valid_decode}, 32'h1);

        // Advance to 0x20
        imem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) tick();
        chk("pre_stall_addr", imem_addr, 32'h20);

        // Stall for two cycles coincident with the ack of 0x20
        stall_decode = 1'b1;
        imem_rdata   = 32'h3333_0020;
        tick();
        chk("held_req",   {31'h0, imem_req}, 32'h0);
        chk("held_addr",  imem_addr, 32'h20);
        chk("held_pc4",   pc_plus4_decode, 32'h20);
        chk("held_valid", {31'h0, valid_decode}, 32'h1);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        tick();
        chk("held2_req",  {31'h0, imem_req}, 32'h0);
        chk("held2_pc4",  pc_plus4_decode, 32'h20);
        stall_decode = 1'b0;
        tick();
        chk("rel_instr", instr_decode, 32'h3333_0020);
        chk("rel_pc4",   pc_plus4_decode, 32'h24);
        chk("rel_valid", {31'h0, valid_decode}, 32'h1);
        chk("rel_req",   {31'h0, imem_req}, 32'h1);
        chk("rel_addr",  imem_addr, 32'h24);

        // Advance to 0x40
        imem_ack = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("pre_br_addr", imem_addr, 32'h40);

        // Branch to 0x100 while the ack for 0x40 is outstanding
        imem_ack         = 1'b0;
        pc_source_decode = 2'b01;
        pc_branch_decode = 32'h100;
        tick();
        chk("pend_addr", imem_addr, 32'h40);
        clear_redirect();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("disc_valid", {31'h0, valid_decode}, 32'h0);
        chk("disc_instr", instr_decode, 32'h0);
        chk("disc_addr",  imem_addr, 32'h100);

        // All redirect sources at once: register jump wins
        pc_source_decode   = 2'b11;
        jump_pc_decode     = 1'b1;
        pc_register_decode = 32'h200;
        pc_jump_decode     = 32'h300;
        pc_branch_decode   = 32'h400;
        tick();
        chk("prio_addr",  imem_addr, 32'h200);
        chk("prio_valid", {31'h0, valid_decode}, 32'h0);

        // Second pending redirect overwrites the first
        clear_redirect();
        imem_ack         = 1'b0;
        pc_source_decode = 2'b01;
        pc_branch_decode = 32'h500;
        tick();
        pc_source_decode = 2'b10;
        pc_jump_decode   = 32'h600;
        tick();
        chk("ovr_hold_addr", imem_addr, 32'h200);
        clear_redirect();
        imem_ack = 1'b1;
        tick();
        chk("ovr_addr", imem_addr, 32'h600);
        imem_rdata = 32'h4444_0044;
        tick();
        chk("post_instr", instr_decode, 32'h4444_0044);
        chk("post_pc4",   pc_plus4_decode, 32'h604);

        // Flush together with ack
        flush_decode = 1'b1;
        imem_rdata   = 32'h5555_0055;
        tick();
        chk("flush_valid", {31'h0, valid_decode}, 32'h0);
        chk("flush_instr", instr_decode, 32'h0);
        chk("flush_addr",  imem_addr, 32'h608);
        flush_decode = 1'b0;

        // PC wrap from 0xFFFF_FFFC
        pc_source_decode = 2'b10;
        pc_jump_decode   = 32'hFFFF_FFFC;
        tick();
        chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
        clear_redirect();
        imem_rdata = 32'h6666_0066;
        tick();
        chk("wrap_instr", instr_decode, 32'h6666_0066);
        chk("wrap_pc4",   pc_plus4_decode, 32'h0);
        chk("wrap_addr",  imem_addr, 32'h0);

        // Reset mid-wait at 0x80
        pc_source_decode = 2'b10;
        pc_jump_decode   = 32'h80;
        tick();
        clear_redirect();
        imem_ack = 1'b0;
        tick();
        chk("mid_req",  {31'h0, imem_req}, 32'h1);
        chk("mid_addr", imem_addr, 32'h80);
        #2;
        reset = 1'b0;
        #1;
        chk("async_req",   {31'h0, imem_req}, 32'h0);
        chk("async_addr",  imem_addr, 32'h0);
        chk("async_valid", {31'h0, valid_decode}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("rb_boot_req", {31'h0, imem_req}, 32'h0);
        tick();
        chk("rb_req",  {31'h0, imem_req}, 32'h1);
        chk("rb_addr", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
